// File: rtl/fifo_wr_rr_arb.sv
// Round-robin arbiter sharing one FIFO write port among N valid/ready requesters.
// With Lock=1 a packet (up to and including its last beat) is never interleaved.
module fifo_wr_rr_arb #(
    parameter int N     = 4,
    parameter int Width = 16,
    parameter int Lock  = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic [N-1:0]             req_valid_i,
    input  logic [N-1:0]             req_last_i,
    input  logic [N*Width-1:0]       req_data_i,
    output logic [N-1:0]             req_ready_o,
    output logic                     fifo_wvalid_o,
    input  logic                     fifo_wready_i,
    output logic [Width-1:0]         fifo_wdata_o,
    output logic [$clog2(N)-1:0]     gnt_idx_o,
    output logic                     locked_o
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } st_e;

    st_e           st_q, st_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] lidx_q, lidx_d;
    logic          en_q, en_d;

    logic          active_s;
    logic          found_s;
    logic          accept_s;
    logic [IW-1:0] win_s;
    logic [IW-1:0] nxt_s;
    logic [IW:0]   sum_s;

    assign active_s = en_q & ~clr_i;

    // Winner selection: locked index, or first valid requester starting at ptr.
    always_comb begin
        found_s = 1'b0;
        win_s   = ptr_q;
        sum_s   = '0;
        if (st_q == LOCKED) begin
            found_s = 1'b1;
            win_s   = lidx_q;
        end else begin
            for (int k = 0; k < N; k++) begin
                sum_s = {1'b0, ptr_q} + (IW+1)'(k);
                if (sum_s >= (IW+1)'(N)) begin
                    sum_s = sum_s - (IW+1)'(N);
                end else begin
                    sum_s = sum_s;
                end
                if (!found_s && req_valid_i[sum_s[IW-1:0]]) begin
                    found_s = 1'b1;
                    win_s   = sum_s[IW-1:0];
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    assign nxt_s = (win_s == IW'(N-1)) ? '0 : win_s + IW'(1);

    // Zero-latency datapath; wready only feeds the per-requester ready.
    always_comb begin
        fifo_wvalid_o = 1'b0;
        fifo_wdata_o  = '0;
        req_ready_o   = '0;
        gnt_idx_o     = '0;
        locked_o      = 1'b0;
        if (active_s) begin
            locked_o = (st_q == LOCKED);
            if (found_s) begin
                gnt_idx_o          = win_s;
                fifo_wvalid_o      = req_valid_i[win_s];
                fifo_wdata_o       = req_data_i[int'(win_s)*Width +: Width];
                req_ready_o[win_s] = fifo_wready_i;
            end else begin
                gnt_idx_o = ptr_q;
            end
        end else begin
            locked_o = 1'b0;
        end
    end

    assign accept_s = fifo_wvalid_o & fifo_wready_i;

    // Arbitration state only advances on an accepted beat; clear wins over everything.
    always_comb begin
        en_d   = 1'b1;
        ptr_d  = ptr_q;
        st_d   = st_q;
        lidx_d = lidx_q;
        if (clr_i) begin
            ptr_d = '0;
            st_d  = IDLE;
        end else if (accept_s) begin
            if ((Lock == 0) || req_last_i[win_s]) begin
                ptr_d = nxt_s;
                st_d  = IDLE;
            end else begin
                lidx_d = win_s;
                st_d   = LOCKED;
            end
        end else begin
            st_d = st_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q  <= '0;
            st_q   <= IDLE;
            lidx_q <= '0;
            en_q   <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            st_q   <= st_d;
            lidx_q <= lidx_d;
            en_q   <= en_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_rr_arb.sv
// Scoreboard bench: stimulus queues expected accepted beats and directed output
// expectations; a single negedge monitor compares them against two DUT instances.
module tb_fifo_wr_rr_arb;

    typedef struct {
        int          cyc;
        int          idx;
        logic [15:0] data;
    } beat_t;

    typedef struct {
        int kind;
        int val;
    } dir_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    int          cyc = 0;

    // Lock=0 instance
    logic [3:0]  v0, l0, rdy0;
    logic [63:0] d0;
    logic        wv0, wr0;
    logic [15:0] wd0;
    logic [1:0]  gnt0;
    logic        lk0;

    // Lock=1 instance
    logic [3:0]  v1, l1, rdy1;
    logic [63:0] d1;
    logic        wv1, wr1;
    logic [15:0] wd1;
    logic [1:0]  gnt1;
    logic        lk1;

    beat_t q0[$];
    beat_t q1[$];
    dir_t  dq[$];

    int    checks = 0;
    int    errors = 0;
    logic  fin = 1'b0;
    logic  fin_done = 1'b0;

    fifo_wr_rr_arb #(.N(4), .Width(16), .Lock(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .req_valid_i(v0), .req_last_i(l0), .req_data_i(d0), .req_ready_o(rdy0),
        .fifo_wvalid_o(wv0), .fifo_wready_i(wr0), .fifo_wdata_o(wd0),
        .gnt_idx_o(gnt0), .locked_o(lk0)
    );

    fifo_wr_rr_arb #(.N(4), .Width(16), .Lock(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .req_valid_i(v1), .req_last_i(l1), .req_data_i(d1), .req_ready_o(rdy1),
        .fifo_wvalid_o(wv1), .fifo_wready_i(wr1), .fifo_wdata_o(wd1),
        .gnt_idx_o(gnt1), .locked_o(lk1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] dat(input int i, input int b);
        return 16'hA000 + 16'(i * 256 + b);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp_v);
        end
    endtask

    // Monitor: scoreboard for accepted beats plus directed per-cycle expectations.
    always @(negedge clk) begin
        beat_t e;
        dir_t  d;
        if (wv0 && wr0) begin
            if (q0.size() == 0) begin
                chk("lock0_unexpected_accept", {30'd0, gnt0}, 32'hFFFF_FFFF);
            end else begin
                e = q0.pop_front();
                chk("lock0_accept_cycle", cyc, e.cyc);
                chk("lock0_gnt", {30'd0, gnt0}, e.idx);
                chk("lock0_data", {16'd0, wd0}, {16'd0, e.data});
                chk("lock0_ready", {28'd0, rdy0}, 32'd1 << e.idx);
            end
        end else if (q0.size() > 0 && q0[0].cyc <= cyc) begin
            e = q0.pop_front();
            chk("lock0_missing_accept", 32'd0, e.idx + 1);
        end
        if (wv1 && wr1) begin
            if (q1.size() == 0) begin
                chk("lock1_unexpected_accept", {30'd0, gnt1}, 32'hFFFF_FFFF);
            end else begin
                e = q1.pop_front();
                chk("lock1_accept_cycle", cyc, e.cyc);
                chk("lock1_gnt", {30'd0, gnt1}, e.idx);
                chk("lock1_data", {16'd0, wd1}, {16'd0, e.data});
                chk("lock1_ready", {28'd0, rdy1}, 32'd1 << e.idx);
            end
        end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
            e = q1.pop_front();
            chk("lock1_missing_accept", 32'd0, e.idx + 1);
        end
        while (dq.size() > 0) begin
            d = dq.pop_front();
            case (d.kind)
                0: chk("wvalid1", {31'd0, wv1}, d.val);
                1: chk("locked1", {31'd0, lk1}, d.val);
                2: chk("gnt1", {30'd0, gnt1}, d.val);
                3: chk("ready1", {28'd0, rdy1}, d.val);
                4: chk("wvalid0", {31'd0, wv0}, d.val);
                5: chk("ready1_bit3", {31'd0, rdy1[3]}, d.val);
                default: chk("bad_kind", d.kind, 32'd0);
            endcase
        end
        if (fin && !fin_done) begin
            chk("q0_drained", q0.size(), 32'd0);
            chk("q1_drained", q1.size(), 32'd0);
            fin_done = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input int kind, input int val);
        dq.push_back('{kind, val});
    endtask

    task automatic exp1(input int i, input int b);
        q1.push_back('{cyc, i, dat(i, b)});
    endtask

    task automatic set1(input logic [3:0] v, input logic [3:0] l, input int b);
        v1 = v;
        l1 = l;
        for (int i = 0; i < 4; i++) d1[i*16 +: 16] = dat(i, b);
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        wr0   = 1'b1;
        wr1   = 1'b1;
        v0    = 4'hF;
        l0    = 4'hF;
        for (int i = 0; i < 4; i++) d0[i*16 +: 16] = dat(i, 0);
        set1(4'hF, 4'hF, 0);

        // Reset gating with every requester valid
        step();
        ex(0, 0); ex(4, 0); ex(1, 0); ex(2, 0); ex(3, 0);
        step();
        rst_n = 1'b1;
        set1(4'h0, 4'h0, 0);
        ex(0, 0); ex(4, 0); ex(3, 0);

        // Lock=0, all valid: accepts 0,1,2,3,0 on consecutive cycles
        for (int k = 0; k < 5; k++) begin
            step();
            q0.push_back('{cyc, k % 4, dat(k % 4, 0)});
        end
        step();
        v0 = 4'h0;

        // Lock=1: 4-beat packet from req0, req1 waits
        step();
        set1(4'b0011, 4'b0010, 0); exp1(0, 0); ex(1, 0); ex(2, 0);
        for (int b = 1; b < 4; b++) begin
            step();
            set1(4'b0011, (b == 3) ? 4'b0011 : 4'b0010, b);
            exp1(0, b); ex(1, 1); ex(2, 0); ex(3, 1);
        end
        step();
        set1(4'b0010, 4'b0010, 0); exp1(1, 0); ex(1, 0);

        // FIFO full while req2 granted in IDLE
        for (int k = 0; k < 3; k++) begin
            step();
            set1(4'b0100, 4'b0100, 0); wr1 = 1'b0;
            ex(0, 1); ex(3, 0); ex(2, 2);
        end
        step();
        wr1 = 1'b1; exp1(2, 0);
        step();
        set1(4'b0000, 4'b0000, 0); ex(2, 3); ex(0, 0);

        // Locked req1 drops valid mid-packet while req3 waits
        step();
        set1(4'b0010, 4'b0000, 0); exp1(1, 0);
        step();
        set1(4'b1010, 4'b1000, 1); exp1(1, 1); ex(1, 1); ex(2, 1);
        for (int k = 0; k < 2; k++) begin
            step();
            set1(4'b1000, 4'b1000, 2);
            ex(0, 0); ex(5, 0); ex(2, 1); ex(1, 1);
        end
        step();
        set1(4'b1010, 4'b1010, 2); exp1(1, 2);
        step();
        set1(4'b1000, 4'b1000, 0); exp1(3, 0); ex(1, 0);

        // Clear while locked on req2 (ptr=2 beforehand)
        step();
        set1(4'b0010, 4'b0010, 0); exp1(1, 0);
        step();
        set1(4'b0100, 4'b0000, 0); exp1(2, 0);
        step();
        set1(4'b0101, 4'b0101, 1); clr = 1'b1;
        ex(0, 0); ex(1, 0); ex(2, 0); ex(3, 0);
        step();
        clr = 1'b0; exp1(0, 1); ex(1, 0);
        step();
        set1(4'b0100, 4'b0100, 1); exp1(2, 1);

        // Reset mid-packet while locked on req3
        step();
        set1(4'b1000, 4'b0000, 0); exp1(3, 0);
        step();
        rst_n = 1'b0; set1(4'b1001, 4'b1001, 1);
        ex(0, 0); ex(1, 0); ex(2, 0); ex(3, 0);
        step();
        rst_n = 1'b1;
        ex(0, 0); ex(1, 0); ex(2, 0);
        step();
        exp1(0, 1); ex(1, 0);
        step();
        set1(4'b0000, 4'b0000, 0); ex(2, 1); ex(0, 0);

        step();
        fin = 1'b1;
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
